// File: rtl/page_splash_pkg.sv
// Shared page-controller types: user input, screen frame, top state, page phase.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package page_splash_pkg;

   localparam int SCREEN_COLS = 32;
   localparam int SCREEN_ROWS = 32;
   localparam int LINE_W      = SCREEN_COLS * 8;

   // One text row: SCREEN_COLS characters, first character in the top byte.
   typedef logic [LINE_W-1:0] line_t;

   localparam line_t BLANK_LINE = {SCREEN_COLS{8'h20}};

   // Whole screen: row r is ScreenText[r].
   typedef logic [SCREEN_ROWS-1:0][LINE_W-1:0] ScreenText;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      MENU   = 3'd1,
      PLAY   = 3'd2,
      RESULT = 3'd3
   } TopState;

   typedef struct packed {
      logic [3:0] arrow_keys;
      logic [3:0] buttons;
   } UserInput;

   typedef struct packed {
      ScreenText text;
      TopState   state;
   } ProgramOutput;

   typedef enum logic [1:0] {
      WAIT_RELEASE = 2'd0,
      ARMED        = 2'd1,
      DONE         = 2'd2
   } PagePhase;

   // Select between a visible line and a blank line of spaces.
   function automatic line_t blink_line(input logic on, input line_t s);
      return on ? s : BLANK_LINE;
   endfunction

endpackage

// File: rtl/page_splash_tick_divider.sv
// Free-running divider: one-cycle wrap pulse every TICKS enabled cycles, never when TICKS = 0.
// Latency: wrap is combinational from the counter register, asserted on the last count.
// Backpressure: none; en simply freezes the count.
module tick_divider #(
   parameter int unsigned TICKS = 500,
   parameter int          CNT_W = 24
) (
   input  logic prog_clk,
   input  logic rst,
   input  logic en,
   output logic wrap
);

   localparam int unsigned LAST_I = (TICKS == 0) ? 0 : TICKS - 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);
   localparam bit ACTIVE = (TICKS != 0);

   logic [CNT_W-1:0] cnt;
   logic             at_last;

   assign at_last = (cnt == LAST);

   // Count 0..TICKS-1 while enabled, wrapping back to 0.
   always_ff @(posedge prog_clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && ACTIVE) begin
         cnt <= at_last ? '0 : cnt + 1'b1;
      end
   end

   // Pulse on the cycle that wraps the counter.
   always_comb begin
      wrap = en && ACTIVE && at_last;
   end

endmodule

// File: rtl/page_splash.sv
// Splash page: title plus blinking prompt, advances on an edge-qualified key press or idle timeout.
// Latency: 1 prog_clk from the qualifying input sample to state/done_pulse change.
// Backpressure: none; key presses during WAIT_RELEASE or DONE are dropped.
module page_splash
   import page_splash_pkg::*;
#(
   parameter int          TITLE_ROW     = 14,
   parameter int          PROMPT_ROW    = 16,
   parameter line_t       TITLE_STR     = "            Welcome!            ",
   parameter line_t       PROMPT_STR    = "    Press [>] to continue...    ",
   parameter logic [3:0]  ADVANCE_KEY   = 4'b0001,
   parameter TopState     SELF_STATE    = INIT,
   parameter TopState     NEXT_STATE    = MENU,
   parameter int unsigned BLINK_TICKS   = 500,
   parameter int unsigned TIMEOUT_TICKS = 0,
   parameter int          CNT_W         = 24
) (
   input  logic         clk,
   input  logic         prog_clk,
   input  logic         rst,
   input  UserInput     user_in,
   output ProgramOutput init_out,
   output logic         done_pulse,
   output logic         timed_out
);

   localparam int unsigned IDLE_LAST_I = (TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LAST_I);
   localparam bit TIMEOUT_EN = (TIMEOUT_TICKS != 0);

   // clk and the button field belong to the uniform page interface only.
   logic unused_ok;
   assign unused_ok = ^{clk, user_in.buttons};

   PagePhase         phase;
   PagePhase         phase_nxt;
   logic [3:0]       keys;
   logic [3:0]       key_prev;
   logic             press;
   logic             timeout_hit;
   logic             enter_done;
   logic             adv_by_timeout;
   logic [CNT_W-1:0] idle_cnt;
   logic             blink_wrap;
   logic             blink_on;
   TopState          state_q;

   assign keys        = user_in.arrow_keys;
   assign press       = (keys == ADVANCE_KEY) && (key_prev != ADVANCE_KEY);
   assign timeout_hit = TIMEOUT_EN && (idle_cnt == IDLE_LAST);

   // Phase register.
   always_ff @(posedge prog_clk) begin
      if (rst) begin
         phase <= WAIT_RELEASE;
      end else begin
         phase <= phase_nxt;
      end
   end

   // Next phase: wait for all keys released, then advance on press or timeout.
   always_comb begin
      phase_nxt = phase;
      case (phase)
         WAIT_RELEASE: if (keys == 4'd0) phase_nxt = ARMED;
         ARMED:        if (press || timeout_hit) phase_nxt = DONE;
         DONE:         phase_nxt = DONE;
         default:      phase_nxt = WAIT_RELEASE;
      endcase
   end

   // Phase decode: the entry edge into DONE and whether the timeout caused it.
   always_comb begin
      enter_done     = (phase == ARMED) && (press || timeout_hit);
      adv_by_timeout = (phase == ARMED) && !press && timeout_hit;
   end

   // Previous-cycle key sample for edge qualification.
   always_ff @(posedge prog_clk) begin
      if (rst) begin
         key_prev <= 4'd0;
      end else begin
         key_prev <= keys;
      end
   end

   // Inactivity counter: clears on any key, saturates on the last timeout tick.
   always_ff @(posedge prog_clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (keys != 4'd0) begin
         idle_cnt <= '0;
      end else if (phase != DONE && idle_cnt != IDLE_LAST) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Reported state, one-cycle completion pulse and sticky timeout flag.
   always_ff @(posedge prog_clk) begin
      if (rst) begin
         state_q    <= SELF_STATE;
         done_pulse <= 1'b0;
         timed_out  <= 1'b0;
      end else begin
         done_pulse <= enter_done;
         if (enter_done) begin
            state_q <= NEXT_STATE;
         end
         if (adv_by_timeout) begin
            timed_out <= 1'b1;
         end
      end
   end

   tick_divider #(
      .TICKS (BLINK_TICKS),
      .CNT_W (CNT_W)
   ) u_blink_div (
      .prog_clk (prog_clk),
      .rst      (rst),
      .en       (phase != DONE),
      .wrap     (blink_wrap)
   );

   // Prompt visibility: toggles on each divider wrap, forced on and frozen once done.
   always_ff @(posedge prog_clk) begin
      if (rst) begin
         blink_on <= 1'b1;
      end else if (enter_done) begin
         blink_on <= 1'b1;
      end else if (phase != DONE && blink_wrap) begin
         blink_on <= ~blink_on;
      end
   end

   // Frame assembly: blank screen, title row, then the prompt row which wins on overlap.
   always_comb begin
      init_out                   = '0;
      init_out.state             = state_q;
      init_out.text[TITLE_ROW]   = TITLE_STR;
      init_out.text[PROMPT_ROW]  = blink_line(blink_on, PROMPT_STR);
   end

endmodule

// File: tb/tb_page_splash.sv
// Directed bench for page_splash with a completion scoreboard.
// Latency: checks the 1-cycle press/timeout to state change.
// Backpressure: not applicable.
module tb_page_splash;
   import page_splash_pkg::*;

   typedef struct {
      TopState state;
      logic    to;
      int      cycle;
   } exp_t;

   localparam logic [255:0] TITLE_L  = "            Welcome!            ";
   localparam logic [255:0] PROMPT_L = "    Press [>] to continue...    ";
   localparam logic [255:0] SPACES_L = {32{8'h20}};

   logic         clk;
   logic         prog_clk;
   logic         rst_b, rst_t;
   UserInput     in_b, in_t;
   ProgramOutput out_b, out_t;
   logic         dp_b, to_b, dp_t, to_t;

   logic         sel;
   ProgramOutput obs_out;
   logic         obs_dp, obs_to;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   page_splash #(.BLINK_TICKS(4), .TIMEOUT_TICKS(0)) u_blk (
      .clk        (clk),
      .prog_clk   (prog_clk),
      .rst        (rst_b),
      .user_in    (in_b),
      .init_out   (out_b),
      .done_pulse (dp_b),
      .timed_out  (to_b)
   );

   page_splash #(.BLINK_TICKS(0), .TIMEOUT_TICKS(8)) u_tmo (
      .clk        (clk),
      .prog_clk   (prog_clk),
      .rst        (rst_t),
      .user_in    (in_t),
      .init_out   (out_t),
      .done_pulse (dp_t),
      .timed_out  (to_t)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;
   initial clk = 1'b0;
   always #7 clk = ~clk;

   assign obs_out = sel ? out_t : out_b;
   assign obs_dp  = sel ? dp_t  : dp_b;
   assign obs_to  = sel ? to_t  : to_b;

   task automatic tick();
      @(posedge prog_clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive(input logic [3:0] k);
      if (sel) in_t.arrow_keys = k;
      else     in_b.arrow_keys = k;
   endtask

   // Two reset edges with the given keys held; afterwards cyc = 0 is the first active cycle.
   task automatic do_reset(input logic [3:0] k);
      drive(k);
      if (sel) rst_t = 1'b1; else rst_b = 1'b1;
      tick();
      tick();
      if (sel) rst_t = 1'b0; else rst_b = 1'b0;
      cyc = 0;
   endtask

   task automatic expect_done(input TopState st, input logic to, input int at);
      exp_t e;
      e.state = st;
      e.to    = to;
      e.cycle = at;
      sb.push_back(e);
   endtask

   // Wait (bounded) for done_pulse, then compare against the oldest expectation.
   task automatic wait_done(input int budget);
      int   n;
      exp_t e;
      n = 0;
      while (!obs_dp && n < budget) begin
         tick();
         n++;
      end
      if (!obs_dp) begin
         chk("done_pulse_timeout", {255'd0, obs_dp}, 256'd1);
      end else if (sb.size() == 0) begin
         chk("unexpected_done", {255'd0, obs_dp}, 256'd0);
      end else begin
         e = sb.pop_front();
         chk("done_state", obs_out.state, e.state);
         chk("done_timed_out", {255'd0, obs_to}, {255'd0, e.to});
         chk("done_cycle", cyc, e.cycle);
         tick();
         chk("done_pulse_width", {255'd0, obs_dp}, 256'd0);
         chk("state_held", obs_out.state, e.state);
      end
   endtask

   initial begin
      rst_b = 1'b1;
      rst_t = 1'b1;
      in_b  = '0;
      in_t  = '0;
      sel   = 1'b0;

      // Basic press on the blinking instance, plus reset values.
      do_reset(4'd0);
      chk("reset_state", obs_out.state, INIT);
      chk("reset_done_pulse", {255'd0, obs_dp}, 256'd0);
      chk("reset_timed_out", {255'd0, obs_to}, 256'd0);
      chk("reset_title", obs_out.text[14], TITLE_L);
      chk("reset_prompt", obs_out.text[16], PROMPT_L);
      chk("reset_row0", obs_out.text[0], 256'd0);
      chk("reset_row15", obs_out.text[15], 256'd0);
      tick();
      tick();
      drive(4'b0001);
      expect_done(MENU, 1'b0, 3);
      tick();
      drive(4'b0000);
      wait_done(20);
      chk("done_title", obs_out.text[14], TITLE_L);
      for (int i = 0; i < 9; i++) begin
         chk("done_prompt_frozen", obs_out.text[16], PROMPT_L);
         tick();
      end

      // Key held through reset must not skip the page.
      do_reset(4'b0001);
      for (int i = 0; i < 10; i++) begin
         chk("held_state", obs_out.state, INIT);
         chk("held_done_pulse", {255'd0, obs_dp}, 256'd0);
         tick();
      end
      drive(4'b0000);
      tick();
      drive(4'b0001);
      expect_done(MENU, 1'b0, 12);
      tick();
      drive(4'b0000);
      wait_done(20);

      // Blink pattern: 4 cycles shown, 4 cycles blank, then frozen visible after advance.
      do_reset(4'd0);
      for (int c = 0; c < 16; c++) begin
         chk("blink_prompt", obs_out.text[16], (((c / 4) % 2) == 0) ? PROMPT_L : SPACES_L);
         chk("blink_title", obs_out.text[14], TITLE_L);
         tick();
      end
      drive(4'b0001);
      expect_done(MENU, 1'b0, 17);
      tick();
      drive(4'b0000);
      wait_done(20);
      for (int i = 0; i < 9; i++) begin
         chk("blink_frozen", obs_out.text[16], PROMPT_L);
         tick();
      end

      // Reset from DONE restores the blinking instance.
      do_reset(4'd0);
      chk("rerst_state", obs_out.state, INIT);
      chk("rerst_prompt", obs_out.text[16], PROMPT_L);

      // Pure inactivity timeout.
      sel = 1'b1;
      do_reset(4'd0);
      chk("tmo_reset_state", obs_out.state, INIT);
      expect_done(MENU, 1'b1, 8);
      wait_done(30);
      tick();
      chk("tmo_sticky", {255'd0, obs_to}, 256'd1);
      chk("tmo_prompt", obs_out.text[16], PROMPT_L);

      // A non-advance key at cycle 5 restarts the idle count.
      do_reset(4'd0);
      for (int i = 0; i < 5; i++) tick();
      drive(4'b0010);
      tick();
      drive(4'b0000);
      for (int i = 0; i < 7; i++) begin
         chk("restart_state", obs_out.state, INIT);
         tick();
      end
      expect_done(MENU, 1'b1, 14);
      wait_done(30);

      // Press on the final timeout cycle counts as a key advance.
      do_reset(4'd0);
      for (int i = 0; i < 7; i++) tick();
      drive(4'b0001);
      expect_done(MENU, 1'b0, 8);
      tick();
      drive(4'b0000);
      wait_done(10);
      chk("coincide_timed_out", {255'd0, obs_to}, 256'd0);

      // Reset in DONE: back to INIT and WAIT_RELEASE, so a press right away is ignored.
      do_reset(4'd0);
      chk("done_rst_state", obs_out.state, INIT);
      chk("done_rst_timed_out", {255'd0, obs_to}, 256'd0);
      chk("done_rst_title", obs_out.text[14], TITLE_L);
      chk("done_rst_prompt", obs_out.text[16], PROMPT_L);
      drive(4'b0001);
      tick();
      drive(4'b0000);
      chk("wait_release_ignores_press", obs_out.state, INIT);
      chk("wait_release_no_pulse", {255'd0, obs_dp}, 256'd0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/page_splash.md
Name: page_splash

Overview:
- Parametrised splash/prompt page for the top-level page controller.
- Drives one ScreenText frame: a title row plus an optionally blinking prompt row; all other rows are blank.
- Advances the top state from SELF_STATE to NEXT_STATE on one of two events:
  - an edge-qualified press of a configurable arrow-key code, or
  - an optional inactivity timeout.
- Key presses are only accepted after all keys have been released once following reset, so a key held through reset cannot skip the page.

Parameters:
- TITLE_ROW, 14: screen row index for the title string.
- PROMPT_ROW, 16: screen row index for the prompt string.
- TITLE_STR, "            Welcome!            ": 32-char title line.
- PROMPT_STR, "    Press [>] to continue...    ": 32-char prompt line.
- ADVANCE_KEY, 4'b0001: arrow_keys code that advances the page.
- SELF_STATE, INIT: TopState value reported while the page is active.
- NEXT_STATE, MENU: TopState value reported after the page advances.
- BLINK_TICKS, 500: prog_clk cycles per prompt blink half-period. 0 = no blink.
- TIMEOUT_TICKS, 0: prog_clk cycles of key inactivity before auto-advance. 0 = disabled.
- CNT_W, 24: width of the blink and timeout counters. Both tick parameters must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; unused, kept for the uniform page interface.
- prog_clk  in  1  program clock; all logic runs on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on prog_clk.
- user_in  in  UserInput  user inputs; only arrow_keys is used.
- init_out  out  ProgramOutput  .text = screen frame, .state = reported TopState.
- done_pulse  out  1  high for exactly one prog_clk cycle when the page advances.
- timed_out  out  1  sticky; set when the advance was caused by the timeout.

Behaviour:
- Reset: rst is synchronous, active-high; clock is prog_clk.
- Reset values:
  - phase = WAIT_RELEASE.
  - init_out.state = SELF_STATE.
  - text: TITLE_ROW = TITLE_STR, PROMPT_ROW = PROMPT_STR, all other rows = '0.
  - blink_on = 1; blink_cnt = 0; idle_cnt = 0; key_prev = 0.
  - done_pulse = 0; timed_out = 0.
- Reset asserted in any phase, including DONE, returns the block to these values on the next edge.
- key_prev is registered arrow_keys from the previous cycle.
- press = (arrow_keys == ADVANCE_KEY) && (key_prev != ADVANCE_KEY).
- Phases:
  - WAIT_RELEASE: blink and timeout counters run. Go to ARMED on the first cycle with arrow_keys == 0. A press in this phase is ignored.
  - ARMED:
    - If press, go to DONE.
    - Else if TIMEOUT_TICKS != 0 and idle_cnt == TIMEOUT_TICKS-1, go to DONE and set timed_out.
  - DONE: terminal until rst.
- Press and timeout in the same cycle: treated as a key advance; timed_out stays 0.
- Timeout counter:
  - idle_cnt clears on any cycle with arrow_keys != 0.
  - Otherwise it increments in WAIT_RELEASE and ARMED, saturating at TIMEOUT_TICKS-1.
- Blink (BLINK_TICKS != 0):
  - blink_cnt counts 0..BLINK_TICKS-1 and wraps to 0.
  - blink_on toggles on each wrap.
  - PROMPT_ROW shows PROMPT_STR when blink_on = 1, else 32 spaces (8'h20 per char).
- BLINK_TICKS == 0: prompt is always shown.
- Entering DONE:
  - On the same edge: init_out.state = NEXT_STATE, done_pulse = 1 for one cycle, prompt forced visible and blink frozen.
  - Outputs are registered, so latency from the qualifying input sample to the state change is 1 prog_clk cycle.
- TITLE_ROW == PROMPT_ROW: the prompt row wins.
- Text rows are written only at reset and by the blink logic; no other rows change.

Decomposition:
- Shared header package (UserInput, ProgramOutput, ScreenText, TopState already there). Add:
  - localparam SCREEN_COLS = 32;
  - localparam BLANK_LINE (32 spaces);
  - typedef enum PagePhase {WAIT_RELEASE, ARMED, DONE}.
- One sub-module is natural: tick_divider (parameters TICKS, CNT_W; outputs a one-cycle wrap pulse; TICKS = 0 means never pulse). Used for blink. The timeout counter stays inline because of its clear and saturate rules.

Test Plan:
- Reset with arrow_keys = 0, wait 2 cycles, arrow_keys = 4'b0001 for 1 cycle -> next cycle state = MENU, done_pulse = 1 for exactly 1 cycle, timed_out = 0; text[14] = title.
- arrow_keys = 4'b0001 held through reset and 10 cycles after -> state stays INIT. Release, then press again -> MENU.
- BLINK_TICKS = 4 -> text[16] alternates PROMPT_STR / BLANK_LINE every 4 cycles. After advance, text[16] = PROMPT_STR constantly.
- TIMEOUT_TICKS = 8, no keys -> MENU after 8 cycles in WAIT_RELEASE/ARMED, timed_out = 1. A press of 4'b0010 at cycle 5 restarts the count.
- Press and final timeout cycle coincide -> MENU, timed_out = 0. Then rst in DONE -> state = INIT, phase WAIT_RELEASE, text restored.
